// File: rtl/fxp_mult_pipe.sv
// fxp_mult_pipe
// Pipelined signed fixed-point multiplier with valid/ready flow control.
// The full-precision product is rounded (half toward +inf), rescaled by FRAC
// bits and either saturated or wrapped to WIDTH bits. A sideband tag and an
// overflow flag travel with every sample. ovf_sticky records any emitted
// overflow until cleared.
//
// Ports
//   clk         rising-edge clock
//   rst_n       synchronous active-low reset
//   in_valid    operand pair valid
//   in_ready    block can accept this cycle (combinational from out_ready)
//   mult_i1/2   signed operands, Q(WIDTH-FRAC).FRAC
//   in_tag      sideband tag carried with the sample
//   mult_o      signed rescaled product
//   out_tag     tag of the sample on mult_o
//   out_ovf     result overflowed (saturated or wrapped)
//   out_valid   result valid
//   out_ready   downstream accepts
//   ovf_sticky  set by any emitted overflowing result
//   ovf_clr     clears ovf_sticky (an overflowing emit in the same cycle wins)
module fxp_mult_pipe #(
    parameter int WIDTH  = 32,
    parameter int FRAC   = 16,
    parameter int STAGES = 3,
    parameter bit SAT    = 1'b1,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] mult_i1,
    input  logic [WIDTH-1:0] mult_i2,
    input  logic [TAG_W-1:0] in_tag,
    output logic [WIDTH-1:0] mult_o,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf_sticky,
    input  logic             ovf_clr
);

    // The full product of two WIDTH-bit signed values fits in 2*WIDTH bits,
    // and adding the rounding half cannot overflow that width.
    localparam int PW     = 2 * WIDTH;
    localparam int RND_SH = (FRAC > 0) ? FRAC - 1 : 0;
    localparam logic signed [PW-1:0] RND = (FRAC > 0) ? (PW'(1) << RND_SH) : '0;

    localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [PW-1:0]    prod;
    logic signed [PW-1:0]    rounded;
    logic signed [PW-1:0]    shifted;
    logic [PW-WIDTH:0]       upper;
    logic                    res_ovf;
    logic [WIDTH-1:0]        res_d;

    logic [STAGES-1:0]       v_q;
    logic [WIDTH-1:0]        data_q [STAGES];
    logic [TAG_W-1:0]        tag_q  [STAGES];
    logic [STAGES-1:0]       ovf_q;

    logic [STAGES-1:0]       en;
    logic [STAGES-1:0]       up_v;
    logic [WIDTH-1:0]        up_d   [STAGES];
    logic [TAG_W-1:0]        up_t   [STAGES];
    logic [STAGES-1:0]       up_o;

    // All arithmetic happens ahead of the first slot; the remaining slots
    // only carry the finished result, so latency is purely the slot count.
    // The shifted value is in range exactly when every bit from the result
    // sign bit upward is a copy of that sign bit.
    always_comb begin
        prod    = PW'($signed(mult_i1)) * PW'($signed(mult_i2));
        rounded = prod + RND;
        shifted = rounded >>> FRAC;
        upper   = shifted[PW-1:WIDTH-1];
        res_ovf = !((&upper) | ~(|upper));
        res_d   = shifted[WIDTH-1:0];
        if (res_ovf && SAT) begin
            res_d = shifted[PW-1] ? MIN_VAL : MAX_VAL;
        end
    end

    // Bubble-collapsing enables: a slot may advance if it is empty or the
    // slot in front of it advances, so empty slots are squeezed out even
    // while the output is stalled.
    always_comb begin
        en = '0;
        en[STAGES-1] = !v_q[STAGES-1] | out_ready;
        for (int k = STAGES - 2; k >= 0; k--) begin
            en[k] = !v_q[k] | en[k+1];
        end
    end

    assign in_ready = en[0];

    // What each slot would load: the new operand result for the first slot,
    // the previous slot's contents for the others.
    always_comb begin
        up_v    = '0;
        up_o    = '0;
        up_v[0] = in_valid & en[0];
        up_d[0] = res_d;
        up_t[0] = in_tag;
        up_o[0] = res_ovf;
        for (int k = 1; k < STAGES; k++) begin
            up_v[k] = v_q[k-1];
            up_d[k] = data_q[k-1];
            up_t[k] = tag_q[k-1];
            up_o[k] = ovf_q[k-1];
        end
    end

    // Slot registers. Valid bits follow the enable; payload registers only
    // load when a real sample arrives so idle slots do not toggle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q   <= '0;
            ovf_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                data_q[k] <= '0;
                tag_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (en[k]) begin
                    v_q[k] <= up_v[k];
                    if (up_v[k]) begin
                        data_q[k] <= up_d[k];
                        tag_q[k]  <= up_t[k];
                        ovf_q[k]  <= up_o[k];
                    end
                end
            end
        end
    end

    // Sticky overflow: an overflowing emit takes priority over a clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_ovf) begin
            ovf_sticky <= 1'b1;
        end else if (ovf_clr) begin
            ovf_sticky <= 1'b0;
        end
    end

    assign mult_o    = data_q[STAGES-1];
    assign out_tag   = tag_q[STAGES-1];
    assign out_ovf   = ovf_q[STAGES-1];
    assign out_valid = v_q[STAGES-1];

endmodule

// File: tb/tb_fxp_mult_pipe.sv
// tb_fxp_mult_pipe
// Drives a saturating and a wrapping instance of fxp_mult_pipe with shared
// stimulus. A queue-based reference model (in-flight samples with their age
// since acceptance) predicts in_ready, out_valid, the result, tag, overflow
// and sticky flag of both instances every cycle; directed cases pin literal
// values from hand calculation.
module tb_fxp_mult_pipe;

    localparam int W  = 16;
    localparam int FR = 8;
    localparam int ST = 3;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [W-1:0]  mult_i1, mult_i2;
    logic [TW-1:0] in_tag;
    logic          out_ready;
    logic          ovf_clr;

    logic          in_ready,   in_ready_w;
    logic [W-1:0]  mult_o,     mult_o_w;
    logic [TW-1:0] out_tag,    out_tag_w;
    logic          out_ovf,    out_ovf_w;
    logic          out_valid,  out_valid_w;
    logic          ovf_sticky, ovf_sticky_w;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fxp_mult_pipe #(.WIDTH(W), .FRAC(FR), .STAGES(ST), .SAT(1'b1), .TAG_W(TW)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mult_i1(mult_i1), .mult_i2(mult_i2), .in_tag(in_tag),
        .mult_o(mult_o), .out_tag(out_tag), .out_ovf(out_ovf),
        .out_valid(out_valid), .out_ready(out_ready),
        .ovf_sticky(ovf_sticky), .ovf_clr(ovf_clr)
    );

    fxp_mult_pipe #(.WIDTH(W), .FRAC(FR), .STAGES(ST), .SAT(1'b0), .TAG_W(TW)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_w),
        .mult_i1(mult_i1), .mult_i2(mult_i2), .in_tag(in_tag),
        .mult_o(mult_o_w), .out_tag(out_tag_w), .out_ovf(out_ovf_w),
        .out_valid(out_valid_w), .out_ready(out_ready),
        .ovf_sticky(ovf_sticky_w), .ovf_clr(ovf_clr)
    );

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
        int            age;
    } item_t;

    item_t         q[$];
    logic [TW-1:0] emitted_tags[$];
    bit            sticky_m   = 1'b0;
    bit            model_live = 1'b0;
    bit            cap_acc = 1'b0, cap_emit = 1'b0, cap_rst = 1'b0, cap_clr = 1'b0;
    logic [W-1:0]  cap_a, cap_b;
    logic [TW-1:0] cap_tag;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on plain integers: exact product, add half an LSB,
    // floor-divide by 2^FR, then range-check against the W-bit signed range.
    function automatic void modelMult(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input bit sat, output logic [W-1:0] d, output bit ovf);
        longint p, r, lo, hi;
        p  = longint'($signed(a)) * longint'($signed(b));
        r  = (p + (longint'(1) <<< (FR - 1))) >>> FR;
        hi = (longint'(1) <<< (W - 1)) - 1;
        lo = -(longint'(1) <<< (W - 1));
        ovf = (r > hi) || (r < lo);
        d = r[W-1:0];
        if (ovf && sat) d = (r > 0) ? 16'h7FFF : 16'h8000;
    endfunction

    // Compare process: mid-cycle, predict every observable output from the
    // model state and capture the handshakes that the next edge will act on.
    always @(negedge clk) begin
        bit           exp_ready, exp_valid, e_ovf, e_ovf_w;
        logic [W-1:0] e_d, e_d_w;
        exp_ready = out_ready || (q.size() < ST);
        exp_valid = (q.size() > 0) && (q[0].age >= ST - 1);
        if (model_live) begin
            checkOutput("in_ready",       32'(in_ready),     32'(exp_ready));
            checkOutput("in_ready_wrap",  32'(in_ready_w),   32'(exp_ready));
            checkOutput("out_valid",      32'(out_valid),    32'(exp_valid));
            checkOutput("out_valid_wrap", 32'(out_valid_w),  32'(exp_valid));
            checkOutput("ovf_sticky",     32'(ovf_sticky),   32'(sticky_m));
            checkOutput("ovf_sticky_wrap",32'(ovf_sticky_w), 32'(sticky_m));
            if (exp_valid) begin
                modelMult(q[0].a, q[0].b, 1'b1, e_d, e_ovf);
                modelMult(q[0].a, q[0].b, 1'b0, e_d_w, e_ovf_w);
                checkOutput("mult_o",       32'(mult_o),    32'(e_d));
                checkOutput("out_tag",      32'(out_tag),   32'(q[0].tag));
                checkOutput("out_ovf",      32'(out_ovf),   32'(e_ovf));
                checkOutput("mult_o_wrap",  32'(mult_o_w),  32'(e_d_w));
                checkOutput("out_tag_wrap", 32'(out_tag_w), 32'(q[0].tag));
                checkOutput("out_ovf_wrap", 32'(out_ovf_w), 32'(e_ovf_w));
            end
        end
        cap_acc  = in_valid && exp_ready;
        cap_emit = exp_valid && out_ready;
        cap_rst  = !rst_n;
        cap_clr  = ovf_clr;
        cap_a    = mult_i1;
        cap_b    = mult_i2;
        cap_tag  = in_tag;
    end

    // Model state update at the active edge, using the captured handshakes.
    always @(posedge clk) begin
        logic [W-1:0] d;
        bit           ovf;
        if (cap_rst) begin
            q.delete();
            sticky_m   = 1'b0;
            model_live = 1'b1;
        end else if (model_live) begin
            if (cap_emit) begin
                modelMult(q[0].a, q[0].b, 1'b1, d, ovf);
                if (ovf) sticky_m = 1'b1;
                else if (cap_clr) sticky_m = 1'b0;
                emitted_tags.push_back(q[0].tag);
                void'(q.pop_front());
            end else if (cap_clr) begin
                sticky_m = 1'b0;
            end
            for (int i = 0; i < q.size(); i++) q[i].age++;
            if (cap_acc) q.push_back('{a: cap_a, b: cap_b, tag: cap_tag, age: 0});
        end
    end

    // Offer one sample and wait (bounded) until it is accepted.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] t);
        bit got;
        int tries;
        mult_i1  = a;
        mult_i2  = b;
        in_tag   = t;
        in_valid = 1'b1;
        tries    = 0;
        got      = 1'b0;
        while (!got && tries < 50) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
            tries++;
        end
        if (!got) checkOutput("accept_timeout", 32'(0), 32'(1));
        in_valid = 1'b0;
    endtask

    // Directed case with literal expectations for both instances.
    task automatic runDirected(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [TW-1:0] t, input logic [W-1:0] exp_sat,
                               input logic [W-1:0] exp_wrap, input bit exp_ovf);
        int n;
        out_ready = 1'b1;
        applyStimulus(a, b, t);
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
            @(negedge clk);
        end
        checkOutput({name, "_latency"}, 32'(n), 32'(ST - 1));
        checkOutput({name, "_data"},    32'(mult_o),   32'(exp_sat));
        checkOutput({name, "_wrap"},    32'(mult_o_w), 32'(exp_wrap));
        checkOutput({name, "_tag"},     32'(out_tag),  32'(t));
        checkOutput({name, "_ovf"},     32'(out_ovf),  32'(exp_ovf));
        @(posedge clk);
        #1;
        @(negedge clk);
        if (exp_ovf) checkOutput({name, "_sticky"}, 32'(ovf_sticky), 32'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        while (q.size() > 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_empty", 32'(q.size()), 32'(0));
    endtask

    initial begin
        int sent, acc, c, base;
        logic [W-1:0] hold;
        logic [W-1:0] ra [8];
        logic [W-1:0] rb [8];

        rst_n = 1'b0; in_valid = 1'b0; mult_i1 = '0; mult_i2 = '0;
        in_tag = '0; out_ready = 1'b1; ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("reset_out_valid", 32'(out_valid),  32'(0));
        checkOutput("reset_mult_o",    32'(mult_o),     32'(0));
        checkOutput("reset_out_tag",   32'(out_tag),    32'(0));
        checkOutput("reset_out_ovf",   32'(out_ovf),    32'(0));
        checkOutput("reset_sticky",    32'(ovf_sticky), 32'(0));
        checkOutput("reset_in_ready",  32'(in_ready),   32'(1));
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        runDirected("basic",    16'h0180, 16'h0200, 4'd5, 16'h0300, 16'h0300, 1'b0);
        runDirected("rnd_up",   16'h0001, 16'h0080, 4'd1, 16'h0001, 16'h0001, 1'b0);
        runDirected("rnd_neg",  16'hFFFF, 16'h0080, 4'd2, 16'h0000, 16'h0000, 1'b0);
        runDirected("rnd_down", 16'h0001, 16'h007F, 4'd3, 16'h0000, 16'h0000, 1'b0);
        runDirected("sat_pos",  16'h7FFF, 16'h0200, 4'd6, 16'h7FFF, 16'hFFFE, 1'b1);
        runDirected("sat_neg",  16'h8000, 16'h0200, 4'd7, 16'h8000, 16'h0000, 1'b1);

        // Clear with no emit, then clear together with an overflowing emit.
        ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        ovf_clr = 1'b0;
        @(negedge clk);
        checkOutput("sticky_cleared", 32'(ovf_sticky), 32'(0));
        @(posedge clk);
        #1;
        ovf_clr = 1'b1;
        runDirected("clr_vs_set", 16'h7FFF, 16'h0200, 4'd9, 16'h7FFF, 16'hFFFE, 1'b1);
        ovf_clr = 1'b0;

        // Fill with the output stalled: exactly ST samples get in.
        out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            mult_i1 = 16'(16'h0100 + acc); mult_i2 = 16'h0100;
            in_tag = 4'(8 + acc); in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checkOutput("fill_count", 32'(acc), 32'(ST));
        @(negedge clk);
        checkOutput("fill_in_ready", 32'(in_ready), 32'(0));
        hold = mult_o;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("stall_hold", 32'(mult_o), 32'(hold));
        @(posedge clk);
        #1;
        drain();

        // Eight back-to-back samples, output stalled for cycles 4..6.
        for (int i = 0; i < 8; i++) begin
            ra[i] = 16'($urandom);
            rb[i] = 16'($urandom);
        end
        base = emitted_tags.size();
        sent = 0;
        c = 0;
        while ((sent < 8 || q.size() > 0) && c < 100) begin
            out_ready = !(c >= 4 && c <= 6);
            in_valid  = (sent < 8);
            mult_i1   = ra[sent % 8];
            mult_i2   = rb[sent % 8];
            in_tag    = 4'(sent);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            c++;
        end
        in_valid = 1'b0;
        checkOutput("burst_count", 32'(emitted_tags.size() - base), 32'(8));
        for (int i = 0; i < 8; i++) begin
            if (base + i < emitted_tags.size())
                checkOutput("burst_order", 32'(emitted_tags[base + i]), 32'(i));
        end

        // Randomised bubbles and backpressure.
        sent = 0;
        c = 0;
        mult_i1 = 16'($urandom);
        mult_i2 = 16'($urandom);
        while (sent < 1000 && c < 20000) begin
            in_valid  = (c % 2 == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 7) == 0);
            in_tag    = 4'(sent);
            @(negedge clk);
            if (in_valid && in_ready) begin
                sent++;
                @(posedge clk);
                #1;
                mult_i1 = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 1) ? 16'h7FFF : 16'h8000)
                                                     : 16'($urandom);
                mult_i2 = 16'($urandom);
            end else begin
                @(posedge clk);
                #1;
            end
            c++;
        end
        checkOutput("random_sent", 32'(sent), 32'(1000));
        ovf_clr = 1'b0;
        drain();

        // Reset with samples in flight.
        runDirected("pre_reset", 16'h7FFF, 16'h0200, 4'd4, 16'h7FFF, 16'hFFFE, 1'b1);
        out_ready = 1'b0;
        applyStimulus(16'h0100, 16'h0100, 4'd1);
        applyStimulus(16'h0200, 16'h0100, 4'd2);
        applyStimulus(16'h0300, 16'h0100, 4'd3);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        checkOutput("rst_out_valid", 32'(out_valid),  32'(0));
        checkOutput("rst_mult_o",    32'(mult_o),     32'(0));
        checkOutput("rst_sticky",    32'(ovf_sticky), 32'(0));
        checkOutput("rst_in_ready",  32'(in_ready),   32'(1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("rst_no_stale", 32'(out_valid), 32'(0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
